uart_mmio: RTL and testbench

Memory-mapped UART peripheral acting as a responder on the CPU data port, behind the memory controller's address decode. It accepts single-cycle register reads and writes from the core's load/store stage. Read data is returned with a registered response one cycle later, which matches the core's writeback-stage capture. Internally it has TX and RX byte FIFOs, an 8N1 transmitter, an oversampled receiver and a programmable baud divisor.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo.sv | 49 ++++
 rtl/uart_mmio.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions, FSM state encodings and the divisor floor.
package uart_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_DIV    = 4'h8;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_RX_OVF   = 5;
  localparam int ST_FRAME    = 6;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; wrap-bit pointers give full/empty, and a push
// on a full FIFO is still taken when a pop retires an entry in the same cycle.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic [W-1:0] mem_r [DEPTH];
  logic         push_ok_s;
  logic         pop_ok_s;

  assign o_empty   = (wr_ptr_r == rd_ptr_r);
  assign o_full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_ok_s  = i_pop && !o_empty;
  assign push_ok_s = i_push && (!o_full || pop_ok_s);
  assign o_data    = mem_r[rd_ptr_r[AW-1:0]];

  // pointer update
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // storage write
  always_ff @(posedge i_clk) begin
    if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART responder: DATA/STATUS/DIVISOR registers, TX and RX
// byte FIFOs, a shift-out transmitter and a mid-bit sampling receiver.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int CLK_DIV_DEFAULT = 217,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  input  logic        i_re,
  output logic [31:0] o_rdata,
  output logic        o_tx,
  input  logic        i_rx
);
  logic        rd_s, wr_s;
  logic [3:0]  reg_s;
  logic [31:0] rdata_s, status_s, rdata_r;
  logic [15:0] div_r;
  logic        ovf_r, ferr_r, ovf_set_s, ferr_set_s;
  logic        unused_s;

  logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s, tx_busy_s;
  logic [7:0]  tx_dout_s;
  tx_state_t   tx_state_r, tx_state_nxt_s;
  logic [15:0] tx_cnt_r, tx_cnt_nxt_s;
  logic [7:0]  tx_shift_r, tx_shift_nxt_s;
  logic [2:0]  tx_bit_r, tx_bit_nxt_s;
  logic        tx_r, tx_nxt_s;

  logic        rx_push_s, rx_pop_s, rx_full_s, rx_empty_s, rx_fall_s;
  logic [7:0]  rx_dout_s;
  logic        rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t   rx_state_r, rx_state_nxt_s;
  logic [15:0] rx_cnt_r, rx_cnt_nxt_s;
  logic [7:0]  rx_shift_r, rx_shift_nxt_s;
  logic [2:0]  rx_bit_r, rx_bit_nxt_s;

  assign unused_s   = ^{i_addr[1:0], i_wdata[31:16]};
  assign rd_s       = i_sel && i_re;
  assign wr_s       = i_sel && i_we;
  assign reg_s      = {i_addr[3:2], 2'b00};
  assign tx_push_s  = wr_s && (reg_s == REG_DATA);
  assign rx_pop_s   = rd_s && (reg_s == REG_DATA) && !rx_empty_s;
  assign tx_busy_s  = (tx_state_r != TX_IDLE) || !tx_empty_s;
  assign ovf_set_s  = rx_push_s && rx_full_s && !rx_pop_s;
  assign rx_fall_s  = rx_prev_r && !rx_sync_r;
  assign o_rdata    = rdata_r;
  assign o_tx       = tx_r;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(tx_push_s), .i_pop(tx_pop_s),
    .i_data(i_wdata[7:0]), .o_data(tx_dout_s), .o_full(tx_full_s), .o_empty(tx_empty_s)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(rx_push_s), .i_pop(rx_pop_s),
    .i_data(rx_shift_r), .o_data(rx_dout_s), .o_full(rx_full_s), .o_empty(rx_empty_s)
  );

  // STATUS word and read-data mux
  always_comb begin
    status_s              = 32'd0;
    status_s[ST_TX_FULL]  = tx_full_s;
    status_s[ST_TX_EMPTY] = tx_empty_s;
    status_s[ST_RX_EMPTY] = rx_empty_s;
    status_s[ST_RX_FULL]  = rx_full_s;
    status_s[ST_TX_BUSY]  = tx_busy_s;
    status_s[ST_RX_OVF]   = ovf_r;
    status_s[ST_FRAME]    = ferr_r;
    rdata_s               = 32'd0;
    case (reg_s)
      REG_DATA: begin
        if (rx_empty_s) rdata_s = 32'h8000_0000;
        else            rdata_s = {24'd0, rx_dout_s};
      end
      REG_STATUS: rdata_s = status_s;
      REG_DIV:    rdata_s = {16'd0, div_r};
      default:    rdata_s = 32'd0;
    endcase
  end

  // bus-side registers: read response, divisor, sticky flags (set wins over clear)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_r <= 32'd0;
      div_r   <= 16'(CLK_DIV_DEFAULT);
      ovf_r   <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      if (rd_s) rdata_r <= rdata_s;
      if (wr_s && (reg_s == REG_DIV))
        div_r <= (i_wdata[15:0] < MIN_DIV) ? MIN_DIV : i_wdata[15:0];
      if (ovf_set_s) ovf_r <= 1'b1;
      else if (wr_s && (reg_s == REG_STATUS) && i_wdata[ST_RX_OVF]) ovf_r <= 1'b0;
      if (ferr_set_s) ferr_r <= 1'b1;
      else if (wr_s && (reg_s == REG_STATUS) && i_wdata[ST_FRAME]) ferr_r <= 1'b0;
    end
  end

  // transmitter next state; o_tx is registered from tx_nxt_s
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    tx_cnt_nxt_s   = tx_cnt_r;
    tx_shift_nxt_s = tx_shift_r;
    tx_bit_nxt_s   = tx_bit_r;
    tx_nxt_s       = tx_r;
    tx_pop_s       = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (!tx_empty_s) begin
          tx_pop_s       = 1'b1;
          tx_shift_nxt_s = tx_dout_s;
          tx_cnt_nxt_s   = div_r - 16'd1;
          tx_nxt_s       = 1'b0;
          tx_state_nxt_s = TX_START;
        end else begin
          tx_nxt_s = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_r == 16'd0) begin
          tx_state_nxt_s = TX_DATA;
          tx_cnt_nxt_s   = div_r - 16'd1;
          tx_bit_nxt_s   = 3'd0;
          tx_nxt_s       = tx_shift_r[0];
        end else begin
          tx_cnt_nxt_s = tx_cnt_r - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == 16'd0) begin
          tx_cnt_nxt_s = div_r - 16'd1;
          if (tx_bit_r == 3'd7) begin
            tx_state_nxt_s = TX_STOP;
            tx_nxt_s       = 1'b1;
          end else begin
            tx_shift_nxt_s = {1'b0, tx_shift_r[7:1]};
            tx_bit_nxt_s   = tx_bit_r + 3'd1;
            tx_nxt_s       = tx_shift_r[1];
          end
        end else begin
          tx_cnt_nxt_s = tx_cnt_r - 16'd1;
        end
      end
      TX_STOP: begin
        // chain straight into the next start bit so queued bytes leave no gap
        if (tx_cnt_r == 16'd0) begin
          if (!tx_empty_s) begin
            tx_pop_s       = 1'b1;
            tx_shift_nxt_s = tx_dout_s;
            tx_cnt_nxt_s   = div_r - 16'd1;
            tx_nxt_s       = 1'b0;
            tx_state_nxt_s = TX_START;
          end else begin
            tx_nxt_s       = 1'b1;
            tx_state_nxt_s = TX_IDLE;
          end
        end else begin
          tx_cnt_nxt_s = tx_cnt_r - 16'd1;
        end
      end
      default: begin
        tx_state_nxt_s = TX_IDLE;
        tx_nxt_s       = 1'b1;
      end
    endcase
  end

  // transmitter state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_shift_r <= 8'd0;
      tx_bit_r   <= 3'd0;
      tx_r       <= 1'b1;
    end else begin
      tx_state_r <= tx_state_nxt_s;
      tx_cnt_r   <= tx_cnt_nxt_s;
      tx_shift_r <= tx_shift_nxt_s;
      tx_bit_r   <= tx_bit_nxt_s;
      tx_r       <= tx_nxt_s;
    end
  end

  // receiver next state: start checked at half a bit, then one sample per bit
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    rx_cnt_nxt_s   = rx_cnt_r;
    rx_shift_nxt_s = rx_shift_r;
    rx_bit_nxt_s   = rx_bit_r;
    rx_push_s      = 1'b0;
    ferr_set_s     = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_fall_s) begin
          rx_state_nxt_s = RX_START;
          rx_cnt_nxt_s   = (div_r >> 1) - 16'd1;
        end else begin
          rx_state_nxt_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == 16'd0) begin
          if (rx_sync_r) begin
            rx_state_nxt_s = RX_IDLE;
          end else begin
            rx_state_nxt_s = RX_DATA;
            rx_cnt_nxt_s   = div_r - 16'd1;
            rx_bit_nxt_s   = 3'd0;
          end
        end else begin
          rx_cnt_nxt_s = rx_cnt_r - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == 16'd0) begin
          rx_shift_nxt_s = {rx_sync_r, rx_shift_r[7:1]};
          rx_cnt_nxt_s   = div_r - 16'd1;
          if (rx_bit_r == 3'd7) rx_state_nxt_s = RX_STOP;
          else                  rx_bit_nxt_s   = rx_bit_r + 3'd1;
        end else begin
          rx_cnt_nxt_s = rx_cnt_r - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == 16'd0) begin
          if (rx_sync_r) rx_push_s  = 1'b1;
          else           ferr_set_s = 1'b1;
          rx_state_nxt_s = RX_IDLE;
        end else begin
          rx_cnt_nxt_s = rx_cnt_r - 16'd1;
        end
      end
      default: rx_state_nxt_s = RX_IDLE;
    endcase
  end

  // receiver synchronizer and state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_shift_r <= 8'd0;
      rx_bit_r   <= 3'd0;
    end else begin
      rx_meta_r  <= i_rx;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      rx_state_r <= rx_state_nxt_s;
      rx_cnt_r   <= rx_cnt_nxt_s;
      rx_shift_r <= rx_shift_nxt_s;
      rx_bit_r   <= rx_bit_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: a register-access vector table followed by
// hand-written serial TX/RX sequences with hand-computed expectations.
module tb_uart_mmio;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel, we, re, rx;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic        tx;
  int          total = 0;
  int          bad   = 0;

  localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_DIV = 4'h8, A_RSV = 4'hC;

  uart_mmio #(.CLK_DIV_DEFAULT(217), .FIFO_DEPTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_addr(addr), .i_wdata(wdata),
    .i_we(we), .i_re(re), .o_rdata(rdata), .o_tx(tx), .i_rx(rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic        w;
    logic        r;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one bus cycle; called at a negedge, returns at the next negedge
  task automatic bus(input logic [3:0] a, input logic w, input logic r, input logic [31:0] d);
    sel = 1'b1; addr = a; we = w; re = r; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; re = 1'b0; wdata = 32'd0;
  endtask

  // check o_tx against one 8N1 frame, one comparison per bit
  task automatic expect_tx(input logic [7:0] b, input int div, input string name);
    logic [9:0] f;
    int         mism;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      mism = 0;
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        if (tx !== f[i]) mism++;
      end
      chk($sformatf("%s_bit%0d", name, i), mism, 32'd0);
    end
  endtask

  // drive one frame on i_rx at 8 clocks per bit, then 4 idle clocks
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (8) @(negedge clk);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    int   n;

    vecs[0]  = '{A_STAT, 1'b0, 1'b1, 32'd0,         32'h0000_0006};
    vecs[1]  = '{A_DIV,  1'b0, 1'b1, 32'd0,         32'd217};
    vecs[2]  = '{A_DATA, 1'b0, 1'b1, 32'd0,         32'h8000_0000};
    vecs[3]  = '{A_RSV,  1'b0, 1'b1, 32'd0,         32'd0};
    vecs[4]  = '{A_RSV,  1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0};
    vecs[5]  = '{A_RSV,  1'b0, 1'b1, 32'd0,         32'd0};
    vecs[6]  = '{A_DIV,  1'b1, 1'b0, 32'd2,         32'd0};
    vecs[7]  = '{A_DIV,  1'b0, 1'b1, 32'd0,         32'd4};
    vecs[8]  = '{A_DIV,  1'b1, 1'b0, 32'h0001_2345, 32'd0};
    vecs[9]  = '{A_DIV,  1'b0, 1'b1, 32'd0,         32'h0000_2345};
    vecs[10] = '{A_DIV,  1'b1, 1'b1, 32'd16,        32'h0000_2345};
    vecs[11] = '{A_DIV,  1'b0, 1'b1, 32'd0,         32'd16};
    vecs[12] = '{A_DIV,  1'b1, 1'b0, 32'd4,         32'd0};
    vecs[13] = '{A_DIV,  1'b0, 1'b1, 32'd0,         32'd4};

    rst = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0; addr = 4'h0; wdata = 32'd0; rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      bus(vecs[i].a, vecs[i].w, vecs[i].r, vecs[i].d);
      if (vecs[i].r) chk($sformatf("vec%0d", i), rdata, vecs[i].exp);
    end

    // single frame 0xA5 at 4 clocks per bit, busy sampled while it runs
    bus(A_DATA, 1'b1, 1'b0, 32'h0000_00A5);
    fork
      expect_tx(8'hA5, 4, "a5");
      begin
        for (int k = 0; k < 3; k++) begin
          repeat (8) @(negedge clk);
          bus(A_STAT, 1'b0, 1'b1, 32'd0);
          chk($sformatf("a5_busy%0d", k), {31'd0, rdata[4]}, 32'd1);
        end
      end
    join
    @(negedge clk);
    bus(A_STAT, 1'b0, 1'b1, 32'd0);
    chk("a5_idle_status", rdata, 32'h0000_0006);

    // fill the TX FIFO on consecutive cycles; the 10th byte is dropped
    bus(A_DIV, 1'b1, 1'b0, 32'd1000);
    for (int i = 0; i < 10; i++) bus(A_DATA, 1'b1, 1'b0, i);
    bus(A_STAT, 1'b0, 1'b1, 32'd0);
    chk("txfull_status", rdata, 32'h0000_0015);
    bus(A_DIV, 1'b1, 1'b0, 32'd4);
    n = 0;
    while (tx !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("byte0_reaches_stop", {31'd0, (n < 2000)}, 32'd1);
    n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) n++;
    end
    chk("byte0_stop", n, 32'd0);
    for (int i = 1; i < 9; i++) expect_tx(i[7:0], 4, $sformatf("burst%0d", i));
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) n++;
    end
    chk("burst_idle_after", n, 32'd0);
    bus(A_STAT, 1'b0, 1'b1, 32'd0);
    chk("burst_done_status", rdata, 32'h0000_0006);

    // receive 0x3C at 8 clocks per bit
    bus(A_DIV, 1'b1, 1'b0, 32'd8);
    send_rx(8'h3C, 1'b1);
    bus(A_STAT, 1'b0, 1'b1, 32'd0);
    chk("rx_status", rdata, 32'h0000_0002);
    bus(A_DATA, 1'b0, 1'b1, 32'd0);
    chk("rx_byte", rdata, 32'h0000_003C);
    bus(A_DATA, 1'b0, 1'b1, 32'd0);
    chk("rx_empty_read", rdata, 32'h8000_0000);

    // 3-clock glitch is a false start
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    bus(A_STAT, 1'b0, 1'b1, 32'd0);
    chk("glitch_status", rdata, 32'h0000_0006);

    // framing error, then clear it
    send_rx(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    bus(A_STAT, 1'b0, 1'b1, 32'd0);
    chk("ferr_status", rdata, 32'h0000_0046);
    bus(A_STAT, 1'b1, 1'b0, 32'h0000_0040);
    bus(A_STAT, 1'b0, 1'b1, 32'd0);
    chk("ferr_cleared", rdata, 32'h0000_0006);

    // overflow: 9 frames into an 8-deep FIFO
    for (int i = 0; i < 9; i++) send_rx(8'h10 + i[7:0], 1'b1);
    bus(A_STAT, 1'b0, 1'b1, 32'd0);
    chk("ovf_status", rdata, 32'h0000_002A);
    for (int i = 0; i < 8; i++) begin
      bus(A_DATA, 1'b0, 1'b1, 32'd0);
      chk($sformatf("ovf_read%0d", i), rdata, 32'h10 + i);
    end
    bus(A_DATA, 1'b0, 1'b1, 32'd0);
    chk("ovf_read_empty", rdata, 32'h8000_0000);

    // reset in the middle of a TX frame
    bus(A_DATA, 1'b1, 1'b0, 32'd0);
    repeat (20) @(negedge clk);
    chk("pre_reset_tx_low", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midframe_reset_tx", {31'd0, tx}, 32'd1);
    chk("midframe_reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    bus(A_STAT, 1'b0, 1'b1, 32'd0);
    chk("post_reset_status", rdata, 32'h0000_0006);
    bus(A_DIV, 1'b0, 1'b1, 32'd0);
    chk("post_reset_div", rdata, 32'd217);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
